// File: rtl/signal_safety_monitor_pkg.sv
// Shared signal codes, lamp patterns, encodings and timing parameters
// for the signal safety monitor.
package signal_safety_monitor_pkg;

   localparam int unsigned MIN_RED_CLEAR = 1;
   localparam int unsigned BLINK_HALF    = 4;
   localparam int unsigned WATCHDOG      = 63;
   localparam int unsigned CNT_W         = 6;
   localparam int unsigned SIG_W         = 2;
   localparam int unsigned LAMP_W        = 3;
   localparam int unsigned FCODE_W       = 3;

   localparam logic [SIG_W-1:0] SIG_G  = 2'b00;
   localparam logic [SIG_W-1:0] SIG_YG = 2'b01;
   localparam logic [SIG_W-1:0] SIG_R  = 2'b10;
   localparam logic [SIG_W-1:0] SIG_RY = 2'b11;

   localparam logic [LAMP_W-1:0] LAMP_RED     = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_RED_YEL = 3'b110;
   localparam logic [LAMP_W-1:0] LAMP_GRN     = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_YEL     = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_OFF     = 3'b000;

   typedef enum logic [FCODE_W-1:0] {
      FC_NONE      = 3'd0,
      FC_CONFLICT  = 3'd1,
      FC_ILLEGAL   = 3'd2,
      FC_CLEARANCE = 3'd3,
      FC_WATCHDOG  = 3'd4
   } fault_code_e;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_MONITOR = 2'd1,
      ST_FAULT   = 2'd2,
      ST_RECOVER = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      GRP_NONE = 2'd0,
      GRP_HW   = 2'd1,
      GRP_FM   = 2'd2
   } group_e;

   typedef struct packed {
      logic [SIG_W-1:0] hw1;
      logic [SIG_W-1:0] hw2;
      logic [SIG_W-1:0] fm1;
      logic [SIG_W-1:0] fm2;
   } sig_set_t;

   function automatic logic [LAMP_W-1:0] lamp_decode(input logic [SIG_W-1:0] code);
      logic [LAMP_W-1:0] lamp;
      lamp = LAMP_RED;
      case (code)
         SIG_G:   lamp = LAMP_GRN;
         SIG_YG:  lamp = LAMP_YEL;
         SIG_RY:  lamp = LAMP_RED_YEL;
         default: lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/signal_safety_monitor_sig_seq_check.sv
// Flags a per-lamp code step that leaves the R -> RY -> G -> YG -> R ring
// (holding the current code is always legal).
module signal_safety_monitor_sig_seq_check
   import signal_safety_monitor_pkg::*;
(
   input  logic [SIG_W-1:0] prev_i,
   input  logic [SIG_W-1:0] cur_i,
   output logic             illegal_c_o
);

   logic legal_c;

   always_comb begin
      legal_c = 1'b0;
      case (prev_i)
         SIG_R:   legal_c = (cur_i == SIG_R)  || (cur_i == SIG_RY);
         SIG_RY:  legal_c = (cur_i == SIG_RY) || (cur_i == SIG_G);
         SIG_G:   legal_c = (cur_i == SIG_G)  || (cur_i == SIG_YG);
         SIG_YG:  legal_c = (cur_i == SIG_YG) || (cur_i == SIG_R);
         default: legal_c = 1'b0;
      endcase
   end

   assign illegal_c_o = !legal_c;

endmodule

// File: rtl/signal_safety_monitor.sv
// Safety monitor between the four-signal light controller and the lamps:
// decodes codes to lamp drives, detects violations, latches the first fault.
module signal_safety_monitor
   import signal_safety_monitor_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [1:0] hw1_sig,
   input  logic [1:0] hw2_sig,
   input  logic [1:0] fm1_sig,
   input  logic [1:0] fm2_sig,
   input  logic       ack_fault,
   output logic [2:0] hw1_lamp,
   output logic [2:0] hw2_lamp,
   output logic [2:0] fm1_lamp,
   output logic [2:0] fm2_lamp,
   output logic       fault,
   output logic [2:0] fault_code
);

   state_e            state_q, state_d;
   sig_set_t          cur_c, prev_q;
   group_e            last_group_q, last_group_d;
   fault_code_e       fault_code_q, fault_code_d, hit_code_c;
   logic [CNT_W-1:0]  allred_cnt_q, allred_cnt_d;
   logic [CNT_W-1:0]  still_cnt_q, still_cnt_d, still_next_c;
   logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;
   logic              fault_q, fault_d;
   logic [LAMP_W-1:0] hw1_lamp_q, hw1_lamp_d, hw2_lamp_q, hw2_lamp_d;
   logic [LAMP_W-1:0] fm1_lamp_q, fm1_lamp_d, fm2_lamp_q, fm2_lamp_d;
   logic [3:0]        illegal_c;
   logic              all_red_c, hw_active_c, fm_active_c, changed_c;
   logic              conflict_c, clear_viol_c, recover_done_c;

   assign cur_c = '{hw1: hw1_sig, hw2: hw2_sig, fm1: fm1_sig, fm2: fm2_sig};

   assign hw_active_c  = (cur_c.hw1 != SIG_R) || (cur_c.hw2 != SIG_R);
   assign fm_active_c  = (cur_c.fm1 != SIG_R) || (cur_c.fm2 != SIG_R);
   assign all_red_c    = !hw_active_c && !fm_active_c;
   assign changed_c    = (cur_c != prev_q);
   assign conflict_c   = hw_active_c && fm_active_c;
   assign clear_viol_c = (allred_cnt_q < CNT_W'(MIN_RED_CLEAR)) &&
                         ((hw_active_c && (last_group_q == GRP_FM)) ||
                          (fm_active_c && (last_group_q == GRP_HW)));
   // Current all-red cycle included, so the count is one ahead of allred_cnt_q.
   assign recover_done_c = all_red_c &&
                           ((CNT_W+1)'(allred_cnt_q) + (CNT_W+1)'(1) >= (CNT_W+1)'(MIN_RED_CLEAR));

   signal_safety_monitor_sig_seq_check u_seq_hw1 (
      .prev_i(prev_q.hw1), .cur_i(cur_c.hw1), .illegal_c_o(illegal_c[0]));
   signal_safety_monitor_sig_seq_check u_seq_hw2 (
      .prev_i(prev_q.hw2), .cur_i(cur_c.hw2), .illegal_c_o(illegal_c[1]));
   signal_safety_monitor_sig_seq_check u_seq_fm1 (
      .prev_i(prev_q.fm1), .cur_i(cur_c.fm1), .illegal_c_o(illegal_c[2]));
   signal_safety_monitor_sig_seq_check u_seq_fm2 (
      .prev_i(prev_q.fm2), .cur_i(cur_c.fm2), .illegal_c_o(illegal_c[3]));

   // Stillness count only runs while monitoring; violation priority encoder.
   always_comb begin
      still_next_c = '0;
      if ((state_q == ST_MONITOR) && !changed_c) begin
         if (go && (still_cnt_q != '1)) still_next_c = still_cnt_q + CNT_W'(1);
         else                           still_next_c = still_cnt_q;
      end

      hit_code_c = FC_NONE;
      if (conflict_c)                                         hit_code_c = FC_CONFLICT;
      else if (|illegal_c)                                    hit_code_c = FC_ILLEGAL;
      else if (clear_viol_c)                                  hit_code_c = FC_CLEARANCE;
      else if (go && (still_next_c == CNT_W'(WATCHDOG)))      hit_code_c = FC_WATCHDOG;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:    if (all_red_c)                  state_d = ST_MONITOR;
         ST_MONITOR: if (hit_code_c != FC_NONE)      state_d = ST_FAULT;
         ST_FAULT:   if (ack_fault && all_red_c)     state_d = ST_RECOVER;
         ST_RECOVER: if (recover_done_c)             state_d = ST_MONITOR;
         default:                                    state_d = ST_INIT;
      endcase
   end

   // Output and bookkeeping next values, keyed on the state being entered
   always_comb begin
      blink_cnt_d  = '0;
      blink_on_d   = 1'b0;
      fault_d      = (state_d == ST_FAULT);
      fault_code_d = fault_code_q;
      last_group_d = last_group_q;
      still_cnt_d  = still_next_c;
      hw1_lamp_d   = LAMP_RED;
      hw2_lamp_d   = LAMP_RED;
      fm1_lamp_d   = LAMP_RED;
      fm2_lamp_d   = LAMP_RED;

      if (state_d == ST_FAULT) begin
         if (state_q != ST_FAULT) begin
            blink_cnt_d = CNT_W'(1);
            blink_on_d  = 1'b1;
         end else if (blink_cnt_q == CNT_W'(BLINK_HALF)) begin
            blink_cnt_d = CNT_W'(1);
            blink_on_d  = !blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
            blink_on_d  = blink_on_q;
         end
      end

      case (state_d)
         ST_MONITOR: begin
            hw1_lamp_d = lamp_decode(cur_c.hw1);
            hw2_lamp_d = lamp_decode(cur_c.hw2);
            fm1_lamp_d = lamp_decode(cur_c.fm1);
            fm2_lamp_d = lamp_decode(cur_c.fm2);
         end
         ST_FAULT: begin
            hw1_lamp_d = blink_on_d ? LAMP_YEL : LAMP_OFF;
            hw2_lamp_d = blink_on_d ? LAMP_YEL : LAMP_OFF;
            fm1_lamp_d = blink_on_d ? LAMP_YEL : LAMP_OFF;
            fm2_lamp_d = blink_on_d ? LAMP_YEL : LAMP_OFF;
         end
         default: ;
      endcase

      if ((state_q == ST_MONITOR) && (state_d == ST_FAULT)) fault_code_d = hit_code_c;
      else if (state_d == ST_RECOVER)                       fault_code_d = FC_NONE;

      if (state_q == ST_RECOVER) begin
         last_group_d = GRP_NONE;
      end else if ((state_q == ST_MONITOR) && (hit_code_c == FC_NONE)) begin
         if (hw_active_c)      last_group_d = GRP_HW;
         else if (fm_active_c) last_group_d = GRP_FM;
      end

      // Recovery clearance is counted afresh from the first RECOVER cycle.
      if ((state_d == ST_RECOVER) && (state_q != ST_RECOVER)) allred_cnt_d = '0;
      else if (!all_red_c)                                    allred_cnt_d = '0;
      else if (allred_cnt_q != '1)                            allred_cnt_d = allred_cnt_q + CNT_W'(1);
      else                                                    allred_cnt_d = allred_cnt_q;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_q       <= '{hw1: SIG_R, hw2: SIG_R, fm1: SIG_R, fm2: SIG_R};
         last_group_q <= GRP_NONE;
         fault_code_q <= FC_NONE;
         allred_cnt_q <= '0;
         still_cnt_q  <= '0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b0;
         fault_q      <= 1'b0;
         hw1_lamp_q   <= LAMP_RED;
         hw2_lamp_q   <= LAMP_RED;
         fm1_lamp_q   <= LAMP_RED;
         fm2_lamp_q   <= LAMP_RED;
      end else begin
         prev_q       <= cur_c;
         last_group_q <= last_group_d;
         fault_code_q <= fault_code_d;
         allred_cnt_q <= allred_cnt_d;
         still_cnt_q  <= still_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_on_q   <= blink_on_d;
         fault_q      <= fault_d;
         hw1_lamp_q   <= hw1_lamp_d;
         hw2_lamp_q   <= hw2_lamp_d;
         fm1_lamp_q   <= fm1_lamp_d;
         fm2_lamp_q   <= fm2_lamp_d;
      end
   end

   assign hw1_lamp   = hw1_lamp_q;
   assign hw2_lamp   = hw2_lamp_q;
   assign fm1_lamp   = fm1_lamp_q;
   assign fm2_lamp   = fm2_lamp_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_signal_safety_monitor.sv
// Directed and randomized bench for signal_safety_monitor against a
// cycle-level behavioural model of the safety rules.
module tb_signal_safety_monitor;

   localparam logic [1:0] G = 2'b00, YG = 2'b01, R = 2'b10, RY = 2'b11;
   localparam int MIN_CLR = 1, BLINK = 4, WD = 63, SAT = 63;

   logic       clk = 1'b0;
   logic       reset = 1'b0, go = 1'b1, ack_fault = 1'b0;
   logic [1:0] hw1_sig = R, hw2_sig = R, fm1_sig = R, fm2_sig = R;
   logic [2:0] hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp, fault_code;
   logic       fault;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: mode 0 idle-wait, 1 watching, 2 flashing, 3 clearing
   int         m_mode, m_allred, m_still, m_last, m_code, m_fcyc;
   logic [1:0] m_prev [4];
   logic [11:0] exp_lamps;
   logic        exp_fault;
   logic [2:0]  exp_code;

   always #5 clk = ~clk;

   signal_safety_monitor dut (
      .clk(clk), .reset(reset), .go(go),
      .hw1_sig(hw1_sig), .hw2_sig(hw2_sig), .fm1_sig(fm1_sig), .fm2_sig(fm2_sig),
      .ack_fault(ack_fault),
      .hw1_lamp(hw1_lamp), .hw2_lamp(hw2_lamp), .fm1_lamp(fm1_lamp), .fm2_lamp(fm2_lamp),
      .fault(fault), .fault_code(fault_code)
   );

   function automatic int seq_pos(input logic [1:0] c);
      case (c)
         R:       return 0;
         RY:      return 1;
         G:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] code_at(input int p);
      case (p % 4)
         0:       return R;
         1:       return RY;
         2:       return G;
         default: return YG;
      endcase
   endfunction

   function automatic bit legal_step(input logic [1:0] p, input logic [1:0] c);
      return (c == p) || (seq_pos(c) == (seq_pos(p) + 1) % 4);
   endfunction

   function automatic logic [2:0] lamp_of(input logic [1:0] c);
      case (c)
         R:       return 3'b100;
         RY:      return 3'b110;
         G:       return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   task automatic model_edge();
      logic [1:0] c [4];
      bit all_r, hw_on, fm_on, changed, bad_seq;
      int hit, still_new, old_mode;
      c[0] = hw1_sig; c[1] = hw2_sig; c[2] = fm1_sig; c[3] = fm2_sig;
      if (!reset) begin
         m_mode = 0; m_allred = 0; m_still = 0; m_last = 0; m_code = 0; m_fcyc = 0;
         for (int i = 0; i < 4; i++) m_prev[i] = R;
      end else begin
         hw_on = (c[0] != R) || (c[1] != R);
         fm_on = (c[2] != R) || (c[3] != R);
         all_r = !hw_on && !fm_on;
         changed = 1'b0;
         bad_seq = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (c[i] != m_prev[i]) changed = 1'b1;
            if (!legal_step(m_prev[i], c[i])) bad_seq = 1'b1;
         end
         still_new = changed ? 0 : (go ? sat_inc(m_still) : m_still);
         old_mode = m_mode;
         case (m_mode)
            0: if (all_r) m_mode = 1;
            1: begin
               hit = 0;
               if (hw_on && fm_on) hit = 1;
               else if (bad_seq) hit = 2;
               else if (((hw_on && m_last == 2) || (fm_on && m_last == 1)) && m_allred < MIN_CLR) hit = 3;
               else if (go && still_new >= WD) hit = 4;
               if (hit != 0) begin
                  m_mode = 2; m_code = hit; m_fcyc = 0;
               end else if (hw_on) m_last = 1;
               else if (fm_on) m_last = 2;
            end
            2: if (ack_fault && all_r) begin m_mode = 3; m_code = 0; end
            default: begin
               m_last = 0;
               if (all_r && m_allred + 1 >= MIN_CLR) m_mode = 1;
            end
         endcase
         if (m_mode == 2) m_fcyc++;
         if (m_mode == 3 && old_mode != 3) m_allred = 0;
         else m_allred = all_r ? sat_inc(m_allred) : 0;
         m_still = (old_mode == 1) ? still_new : 0;
         for (int i = 0; i < 4; i++) m_prev[i] = c[i];
      end
      if (m_mode == 1)
         exp_lamps = {lamp_of(c[0]), lamp_of(c[1]), lamp_of(c[2]), lamp_of(c[3])};
      else if (m_mode == 2)
         exp_lamps = (((m_fcyc - 1) / BLINK) % 2 == 0) ? {4{3'b010}} : 12'b0;
      else
         exp_lamps = {4{3'b100}};
      exp_fault = (m_mode == 2);
      exp_code  = 3'(m_code);
   endtask

   task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick(input logic [1:0] h1, input logic [1:0] h2, input logic [1:0] f1,
                       input logic [1:0] f2, input string tag, input logic a = 1'b0,
                       input logic g = 1'b1, input logic r = 1'b1);
      hw1_sig = h1; hw2_sig = h2; fm1_sig = f1; fm2_sig = f2;
      ack_fault = a; go = g; reset = r;
      @(posedge clk);
      model_edge();
      #1;
      n_assert++;
      assert ({hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp, fault, fault_code} ===
              {exp_lamps, exp_fault, exp_code})
      else begin
         n_fail++;
         $error("FAIL %s: observed lamps=%b fault=%b code=%0d expected lamps=%b fault=%b code=%0d",
                tag, {hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp}, fault, fault_code,
                exp_lamps, exp_fault, exp_code);
      end
   endtask

   initial begin
      logic [1:0] rv [4];

      // Reset and normal highway then farm cycle
      tick(R, R, R, R, "reset0", 1'b0, 1'b1, 1'b0);
      tick(R, R, R, R, "reset1", 1'b1, 1'b1, 1'b0);
      check_val("reset_lamps", {hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp}, {4{3'b100}});
      tick(R, R, R, R, "init_exit");
      tick(RY, RY, R, R, "hw_ry");
      check_val("hw1_ry_lamp", 12'(hw1_lamp), 12'(3'b110));
      tick(G, G, R, R, "hw_g");
      tick(YG, YG, R, R, "hw_yg");
      tick(R, R, R, R, "hw_r");
      repeat (3) tick(R, R, R, R, "allred");
      tick(R, R, RY, RY, "fm_ry");
      tick(R, R, G, G, "fm_g");
      check_val("fm1_g_lamp", 12'(fm1_lamp), 12'(3'b001));
      tick(R, R, YG, YG, "fm_yg");
      tick(R, R, R, R, "fm_r");
      check_val("normal_no_fault", 12'(fault), 12'(0));

      // Conflict and flash pattern
      tick(G, R, RY, R, "conflict");
      check_val("conflict_code", 12'(fault_code), 12'(1));
      repeat (12) tick(G, R, RY, R, "flash");
      tick(R, R, R, R, "ack1", 1'b1);
      tick(R, R, R, R, "rec1");
      tick(R, R, R, R, "mon1");

      // Illegal jump, later conflict must not overwrite
      tick(R, G, R, R, "illegal");
      check_val("illegal_code", 12'(fault_code), 12'(2));
      tick(G, R, G, R, "late_conflict");
      check_val("code_held", 12'(fault_code), 12'(2));
      tick(R, R, R, R, "ack2", 1'b1);
      tick(R, R, R, R, "rec2");

      // Clearance violation, then the legal variant
      tick(RY, R, R, R, "c_ry");
      tick(G, R, R, R, "c_g");
      tick(YG, R, R, R, "c_yg");
      tick(R, R, RY, R, "clear_viol");
      check_val("clear_code", 12'(fault_code), 12'(3));
      tick(R, R, R, R, "ack3", 1'b1);
      tick(R, R, R, R, "rec3");
      tick(RY, R, R, R, "c2_ry");
      tick(G, R, R, R, "c2_g");
      tick(YG, R, R, R, "c2_yg");
      tick(R, R, R, R, "c2_r");
      tick(R, R, RY, R, "clear_ok");
      check_val("clear_ok_fault", 12'(fault), 12'(0));
      tick(R, R, G, R, "c2_fg");
      tick(R, R, YG, R, "c2_fyg");

      // Watchdog with go=1, then a long hold with go=0
      repeat (70) tick(R, R, R, R, "hold_go1");
      check_val("watchdog_code", 12'(fault_code), 12'(4));
      tick(R, R, R, R, "ack4", 1'b1, 1'b0);
      repeat (200) tick(R, R, R, R, "hold_go0", 1'b0, 1'b0);
      check_val("go0_no_fault", 12'(fault), 12'(0));
      repeat (5) tick(R, R, R, R, "go_resume");

      // Ack ignored unless all red; recovery path
      tick(G, R, G, R, "conflict2");
      tick(G, R, R, R, "ack_not_red", 1'b1);
      check_val("ack_ignored", 12'(fault), 12'(1));
      tick(R, R, R, R, "ack_red", 1'b1);
      check_val("recover_lamps", {hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp}, {4{3'b100}});
      check_val("recover_code", 12'(fault_code), 12'(0));
      tick(R, R, R, R, "to_monitor");

      // Reset mid-flash overrides ack
      tick(G, R, G, R, "conflict3");
      repeat (5) tick(G, R, G, R, "flash3");
      tick(R, R, R, R, "reset_mid", 1'b1, 1'b1, 1'b0);
      check_val("reset_mid_lamps", {hw1_lamp, hw2_lamp, fm1_lamp, fm2_lamp}, {4{3'b100}});
      check_val("reset_mid_fault", 12'(fault), 12'(0));
      tick(R, R, R, R, "reinit");

      // Randomized mostly-legal traffic with injected faults, acks and resets
      for (int i = 0; i < 4; i++) rv[i] = R;
      for (int k = 0; k < 400; k++) begin
         int unsigned r;
         int          j;
         r = $urandom_range(0, 99);
         j = int'($urandom_range(0, 3));
         if (r < 60) begin
            if ((j < 2 && rv[2] == R && rv[3] == R) || (j >= 2 && rv[0] == R && rv[1] == R))
               rv[j] = code_at(seq_pos(rv[j]) + 1);
         end else if (r < 64) begin
            rv[j] = 2'($urandom_range(0, 3));
         end else if (r < 74) begin
            for (int i = 0; i < 4; i++) rv[i] = R;
         end
         tick(rv[0], rv[1], rv[2], rv[3], "random",
              logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 9) != 0),
              logic'($urandom_range(0, 99) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
